project_select_ctrl: RTL and testbench
======================================

Name: project_select_ctrl

Overview:
- Wishbone-programmable project activation controller for the multi-project user area.
- Replaces hard-wired logic-analyser "active" bits with a register-driven one-hot select of NUM_PROJECTS slots.
- Sequences every switch as: all-off gap, then target enabled under a held reset, then released.
- Gives a status/IRQ handshake so firmware knows when the new project is live.

Parameters:
- NUM_PROJECTS, 16, number of project slots (2..256); sets width of active_o.
- BASE_ADDR, 32'h3000_0000, Wishbone base; decode on adr[31:8].
- GAP_CYCLES, 4, all-off cycles between deselect and select (>=1).
- RST_CYCLES, 8, cycles proj_rst_o is held high after the new slot is enabled (>=1).

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_n_i  in  1  asynchronous active-low reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte lanes; ignored, all writes are full-word.
- wbs_adr_i  in  32  address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge; 0 when not addressed (OR-combined bus).
- wbs_dat_o  out  32  read data; 0 when not acking.
- active_o  out  NUM_PROJECTS  one-hot or all-zero project enable.
- proj_rst_o  out  1  active-high reset to the selected project.
- irq_o  out  1  one-cycle pulse on switch completion.

Behaviour:
- Reset (async assert, sync release) values:
  - active_o=0, proj_rst_o=1, irq_o=0, wbs_ack_o=0, wbs_dat_o=0.
  - FSM=IDLE; cur_idx=0, valid=0, err=0, sw_count=0.
- Address decode:
  - hit = stb & cyc & (adr[31:8]==BASE_ADDR[31:8]).
  - wbs_ack_o is registered and asserts the cycle after hit.
  - ack is held low for one cycle after any ack, so a held strobe gives exactly one ack per two cycles.
  - No ack outside the window.
- Registers (offset = adr[3:2]):
  - 0x00 CTRL, write: [7:0]=idx, [8]=en. Reads back the last written value.
  - 0x04 STATUS, read: [7:0]=cur_idx, [8]=valid, [9]=busy, [10]=err. Writing 1 to bit 10 clears err; other bits ignored.
  - 0x08 SW_COUNT, read-only: [15:0], saturating at 0xFFFF, counts completed switches.
  - 0x0C ID, read-only: [8:0]=NUM_PROJECTS.
  - Writes to read-only registers are acked and have no effect. Reads take one cycle (data is valid with ack).
- FSM states: IDLE, GAP, RESET, RUN.
  - CTRL write accepted in IDLE or RUN → GAP. Target latched.
  - On GAP entry: active_o=0, proj_rst_o=1, busy=1, valid=0, counter=GAP_CYCLES-1.
  - GAP, counter==0 with en=1 and idx<NUM_PROJECTS → RESET: active_o[idx]=1, proj_rst_o=1, cur_idx=idx, counter=RST_CYCLES-1.
  - GAP, counter==0 with en=0 → IDLE: active_o=0, valid=0, busy=0, no irq, sw_count unchanged.
  - GAP, counter==0 with idx>=NUM_PROJECTS → IDLE with err=1; active_o stays 0.
  - RESET, counter==0 → RUN: proj_rst_o=0, valid=1, busy=0, irq_o pulses 1 cycle, sw_count += 1.
- Latency from CTRL ack to proj_rst_o falling is exactly GAP_CYCLES+RST_CYCLES+1 cycles. active_o is one-hot or zero in every cycle.
- CTRL write while busy (GAP/RESET): acked, ignored, err=1, sequence continues unchanged.
- CTRL write selecting the current idx in RUN performs the full sequence; this is the soft-reset path for a project.
- Simultaneous err-clear write and err-set event in the same cycle: set wins.
- Async reset mid-sequence: immediate return to reset values; no irq.

Decomposition:
- Package project_select_pkg holds:
  - state enum (IDLE, GAP, RESET, RUN);
  - register offsets CTRL/STATUS/SW_COUNT/ID;
  - STATUS bit positions.
- One sub-module, wb_reg_slave, owns address decode, ack generation and read mux.
- The FSM and counters stay in the top.

Test Plan:
1. Reset, then read ID → ack in 1 cycle, data=16. STATUS=0. active_o=0, proj_rst_o=1.
2. Write CTRL=0x105 (GAP=4, RST=8):
   - active_o=0 for 4 cycles, then active_o=16'h0020 with proj_rst_o=1 for 8 cycles.
   - proj_rst_o falls 13 cycles after ack.
   - irq_o pulses once. STATUS=0x105, SW_COUNT=1.
3. In RUN at idx 5, write CTRL=0x109 → gap with active_o=0, then active_o=16'h0200. Never two bits set. SW_COUNT=2.
4. Write CTRL=0x105, then CTRL=0x103 two cycles later → second write acked, err=1, final active_o=16'h0020. Write STATUS=0x400 → err=0.
5. Write CTRL=0x114 (idx 20 ≥ 16) → active_o=0, valid=0, err=1, no irq. Write CTRL=0x000 → all off, busy clears after 4 cycles.
6. Deassert wb_rst_n_i during RESET state → active_o=0 and proj_rst_o=1 in the same cycle. Access to BASE_ADDR+0x100 → no ack.

Source files
------------

// File: rtl/project_select_pkg.sv
// Shared types, register map and STATUS layout for the project select controller.
package project_select_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned IDX_W      = 8;
  localparam int unsigned CTRL_W     = 9;
  localparam int unsigned SW_COUNT_W = 16;
  localparam int unsigned NUM_W      = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAP   = 2'd1,
    ST_RESET = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  // Register offsets, selected by adr[3:2]
  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_SW_COUNT = 2'd2;
  localparam logic [1:0] REG_ID       = 2'd3;

  localparam int unsigned CTRL_EN_BIT      = 8;
  localparam int unsigned STATUS_VALID_BIT = 8;
  localparam int unsigned STATUS_BUSY_BIT  = 9;
  localparam int unsigned STATUS_ERR_BIT   = 10;

  // Register write handed from the bus slave to the controller
  typedef struct packed {
    logic [1:0]        off;
    logic [DATA_W-1:0] data;
  } reg_wr_t;

  // Assemble the STATUS read word
  function automatic logic [DATA_W-1:0] pack_status(input logic [IDX_W-1:0] cur_idx,
                                                    input logic valid,
                                                    input logic busy,
                                                    input logic err);
    logic [DATA_W-1:0] s;
    s                   = '0;
    s[IDX_W-1:0]        = cur_idx;
    s[STATUS_VALID_BIT] = valid;
    s[STATUS_BUSY_BIT]  = busy;
    s[STATUS_ERR_BIT]   = err;
    return s;
  endfunction

endpackage

// File: rtl/project_select_ctrl_wb_reg_slave.sv
// Wishbone slave: address decode, registered ack with one idle cycle, read mux.
module wb_reg_slave
  import project_select_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stb,
  input  logic              cyc,
  input  logic              we,
  input  logic [31:0]       adr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rd_ctrl,
  input  logic [DATA_W-1:0] rd_status,
  input  logic [DATA_W-1:0] rd_count,
  input  logic [DATA_W-1:0] rd_id,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              wr_valid,
  output reg_wr_t           wr
);

  logic              hit_c;
  logic              accept_c;
  logic [DATA_W-1:0] rd_mux_c;
  logic              unused_adr;

  assign hit_c      = stb & cyc & (adr[31:8] == BASE_ADDR[31:8]);
  assign accept_c   = hit_c & ~ack;
  assign unused_adr = ^{adr[7:4], adr[1:0]};

  // Read data selection by word offset
  always_comb begin
    rd_mux_c = '0;
    unique case (adr[3:2])
      REG_CTRL:     rd_mux_c = rd_ctrl;
      REG_STATUS:   rd_mux_c = rd_status;
      REG_SW_COUNT: rd_mux_c = rd_count;
      REG_ID:       rd_mux_c = rd_id;
      default:      rd_mux_c = '0;
    endcase
  end

  // Ack, read data and write strobe registered together; data is zero when not acking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack      <= 1'b0;
      rdata    <= '0;
      wr_valid <= 1'b0;
      wr       <= '0;
    end else begin
      ack      <= accept_c;
      wr_valid <= accept_c & we;
      rdata    <= (accept_c & ~we) ? rd_mux_c : '0;
      if (accept_c) begin
        wr.off  <= adr[3:2];
        wr.data <= wdata;
      end
    end
  end

endmodule

// File: rtl/project_select_ctrl.sv
// Register-driven one-hot project select with gap / held-reset / release sequencing.
module project_select_ctrl
  import project_select_pkg::*;
#(
  parameter int unsigned NUM_PROJECTS = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int unsigned GAP_CYCLES   = 4,
  parameter int unsigned RST_CYCLES   = 8
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [NUM_PROJECTS-1:0] active_o,
  output logic                    proj_rst_o,
  output logic                    irq_o
);

  localparam int unsigned CNT_MAX = (GAP_CYCLES > RST_CYCLES) ? GAP_CYCLES : RST_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_PROJECTS-1:0] active_q, active_d;
  logic                    prst_q, prst_d;
  logic                    irq_q, irq_d;
  logic [IDX_W-1:0]        cur_idx_q, cur_idx_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
  logic [SW_COUNT_W-1:0]   sw_count_q, sw_count_d;
  logic [IDX_W-1:0]        tgt_idx_q, tgt_idx_d;
  logic                    tgt_en_q, tgt_en_d;
  logic [CTRL_W-1:0]       ctrl_q, ctrl_d;

  logic                    wr_valid;
  reg_wr_t                 wr;
  logic                    ctrl_wr_c;
  logic                    err_clr_c;
  logic                    err_set_c;
  logic                    busy_c;
  logic                    tgt_ok_c;
  logic                    unused_bits;

  assign ctrl_wr_c   = wr_valid & (wr.off == REG_CTRL);
  assign err_clr_c   = wr_valid & (wr.off == REG_STATUS) & wr.data[STATUS_ERR_BIT];
  assign busy_c      = (state_q == ST_GAP) | (state_q == ST_RESET);
  assign tgt_ok_c    = NUM_W'(tgt_idx_q) < NUM_W'(NUM_PROJECTS);
  assign unused_bits = ^{wbs_sel_i, wr.data[31:11], wr.data[9]};

  wb_reg_slave #(
    .BASE_ADDR (BASE_ADDR)
  ) u_wb_reg_slave (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .stb       (wbs_stb_i),
    .cyc       (wbs_cyc_i),
    .we        (wbs_we_i),
    .adr       (wbs_adr_i),
    .wdata     (wbs_dat_i),
    .rd_ctrl   (DATA_W'(ctrl_q)),
    .rd_status (pack_status(cur_idx_q, valid_q, busy_c, err_q)),
    .rd_count  (DATA_W'(sw_count_q)),
    .rd_id     (DATA_W'(NUM_W'(NUM_PROJECTS))),
    .ack       (wbs_ack_o),
    .rdata     (wbs_dat_o),
    .wr_valid  (wr_valid),
    .wr        (wr)
  );

  // State, counters and registered outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      active_q   <= '0;
      prst_q     <= 1'b1;
      irq_q      <= 1'b0;
      cur_idx_q  <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      sw_count_q <= '0;
      tgt_idx_q  <= '0;
      tgt_en_q   <= 1'b0;
      ctrl_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      prst_q     <= prst_d;
      irq_q      <= irq_d;
      cur_idx_q  <= cur_idx_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      sw_count_q <= sw_count_d;
      tgt_idx_q  <= tgt_idx_d;
      tgt_en_q   <= tgt_en_d;
      ctrl_q     <= ctrl_d;
    end
  end

  // Switch sequencing: all-off gap, enable under held reset, then release
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    prst_d     = prst_q;
    irq_d      = 1'b0;
    cur_idx_d  = cur_idx_q;
    valid_d    = valid_q;
    sw_count_d = sw_count_q;
    tgt_idx_d  = tgt_idx_q;
    tgt_en_d   = tgt_en_q;
    ctrl_d     = ctrl_q;
    err_set_c  = 1'b0;

    if (ctrl_wr_c) ctrl_d = wr.data[CTRL_W-1:0];

    unique case (state_q)
      ST_IDLE, ST_RUN: begin
        if (ctrl_wr_c) begin
          state_d   = ST_GAP;
          cnt_d     = CNT_W'(GAP_CYCLES - 1);
          active_d  = '0;
          prst_d    = 1'b1;
          valid_d   = 1'b0;
          tgt_idx_d = wr.data[IDX_W-1:0];
          tgt_en_d  = wr.data[CTRL_EN_BIT];
        end
      end
      ST_GAP: begin
        if (ctrl_wr_c) err_set_c = 1'b1;
        if (cnt_q == '0) begin
          if (!tgt_en_q) begin
            state_d = ST_IDLE;
          end else if (!tgt_ok_c) begin
            state_d   = ST_IDLE;
            err_set_c = 1'b1;
          end else begin
            state_d   = ST_RESET;
            active_d  = NUM_PROJECTS'(1) << tgt_idx_q;
            cur_idx_d = tgt_idx_q;
            cnt_d     = CNT_W'(RST_CYCLES - 1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESET: begin
        if (ctrl_wr_c) err_set_c = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_RUN;
          prst_d  = 1'b0;
          valid_d = 1'b1;
          irq_d   = 1'b1;
          if (sw_count_q != '1) sw_count_d = sw_count_q + SW_COUNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A set event in the same cycle as a clear wins
    err_d = err_q;
    if (err_clr_c) err_d = 1'b0;
    if (err_set_c) err_d = 1'b1;
  end

  assign active_o   = active_q;
  assign proj_rst_o = prst_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_project_select_ctrl.sv
// Bench for project_select_ctrl: timeline reference model, per-cycle compare, random traffic.
module tb_project_select_ctrl;

  localparam int          N    = 16;
  localparam int          G    = 4;
  localparam int          R    = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [N-1:0] active;
  logic        prst, irq;

  project_select_ctrl #(
    .NUM_PROJECTS (N),
    .BASE_ADDR    (BASE),
    .GAP_CYCLES   (G),
    .RST_CYCLES   (R)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .active_o   (active),
    .proj_rst_o (prst),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Reference model: values expected during the current cycle
  logic [N-1:0] m_active;
  logic         m_rst, m_valid, m_err;
  logic [7:0]   m_cur;
  int           m_swc;
  logic [8:0]   m_ctrl;
  // Pending switch, described by the cycle its CTRL write was acked
  bit           seq_on, seq_good, seq_bad;
  int           seq_t0, seq_end;
  logic [7:0]   seq_idx;
  int           irq_at, clr_at, set_at, exp_ack_at;
  bit           in_reset = 1'b1;
  bit           ack_chk = 1'b1;

  function automatic void model_reset();
    m_active = '0; m_rst = 1'b1; m_valid = 1'b0; m_err = 1'b0;
    m_cur = '0; m_swc = 0; m_ctrl = '0;
    seq_on = 1'b0; seq_good = 1'b0; seq_bad = 1'b0; seq_t0 = 0; seq_end = 0; seq_idx = '0;
    irq_at = -1; clr_at = -1; set_at = -1; exp_ack_at = -1;
  endfunction

  function automatic void finish_seq();
    if (seq_good) begin
      m_active = N'(1) << seq_idx;
      m_rst    = 1'b0;
      m_valid  = 1'b1;
      m_cur    = seq_idx;
      if (m_swc < 65535) m_swc++;
      irq_at   = seq_t0 + seq_end;
    end else if (seq_bad) begin
      m_err = 1'b1;
    end
    seq_on = 1'b0;
  endfunction

  // A CTRL write acked in cycle t0 takes effect from t0+1, or is rejected if a switch is in flight
  function automatic void model_ctrl_write(input int t0, input logic [31:0] d);
    m_ctrl = d[8:0];
    if (seq_on && (t0 - seq_t0) < seq_end) begin
      set_at = t0 + 1;
      return;
    end
    if (seq_on) finish_seq();
    seq_on   = 1'b1;
    seq_t0   = t0;
    seq_idx  = d[7:0];
    seq_good = d[8] && (int'(d[7:0]) < N);
    seq_bad  = d[8] && !(int'(d[7:0]) < N);
    seq_end  = seq_good ? (G + R + 1) : (G + 1);
  endfunction

  // Expected read data for an access acked in cycle t (reflects cycle t-1)
  function automatic logic [31:0] exp_reg(input logic [1:0] off, input int t);
    int   k;
    logic busy;
    k    = t - 1 - seq_t0;
    busy = seq_on && (k >= 1) && (k < seq_end);
    case (off)
      2'd0:    return 32'(m_ctrl);
      2'd1:    return {21'b0, m_err, busy, m_valid, m_cur};
      2'd2:    return 32'(m_swc[15:0]);
      default: return 32'(N);
    endcase
  endfunction

  // Advance the model and compare the outputs every cycle
  always @(negedge clk) begin
    int k;
    if (!in_reset) begin
      if (cyc_n == clr_at) m_err = 1'b0;
      if (seq_on) begin
        k = cyc_n - seq_t0;
        if (k == seq_end) begin
          finish_seq();
        end else if (k >= 1) begin
          m_rst   = 1'b1;
          m_valid = 1'b0;
          if (seq_good && k > G) begin
            m_active = N'(1) << seq_idx;
            m_cur    = seq_idx;
          end else begin
            m_active = '0;
          end
        end
      end
      if (cyc_n == set_at) m_err = 1'b1;
      check("active_o", 32'(active), 32'(m_active));
      check("proj_rst_o", 32'(prst), 32'(m_rst));
      check("irq_o", 32'(irq), 32'(cyc_n == irq_at));
      check("onehot0", 32'($onehot0(active)), 32'd1);
      if (ack_chk) check("ack_timing", 32'(ack), 32'(cyc_n == exp_ack_at));
      if (!ack) check("dat_idle_zero", rdat, 32'd0);
    end
  end

  task automatic wb_acc(input bit w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int t_ack);
    bit hit_exp;
    hit_exp = (a[31:8] == BASE[31:8]);
    rd      = '0;
    t_ack   = -1;
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = 4'hF;
    if (hit_exp) exp_ack_at = cyc_n + 1;
    for (int i = 0; i < 4 && t_ack < 0; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        t_ack = cyc_n;
        rd    = rdat;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (hit_exp) check("ack_seen", 32'(t_ack == exp_ack_at), 32'd1);
    else         check("no_ack_foreign", 32'(t_ack), 32'hFFFF_FFFF);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, output int t_ack);
    logic [31:0] rd;
    wb_acc(1'b1, a, d, rd, t_ack);
    if (t_ack >= 0) begin
      if (a[3:2] == 2'd0) model_ctrl_write(t_ack, d);
      if (a[3:2] == 2'd1 && d[10]) clr_at = t_ack + 1;
    end
  endtask

  // Read and compare against the model; returns the value for literal checks
  task automatic wb_read(input string name, input logic [1:0] off, output logic [31:0] v);
    int t;
    wb_acc(1'b0, BASE | 32'({off, 2'b00}), 32'd0, v, t);
    if (t >= 0) check(name, v, exp_reg(off, t));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    logic [31:0] v;
    int          t0, fall, irqs, t;
    logic        prev;

    model_reset();
    @(posedge clk); #1;
    check("rst_active", 32'(active), 32'd0);
    check("rst_proj_rst", 32'(prst), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; in_reset = 1'b0;

    // 1: ID and STATUS after reset
    wb_read("id", 2'd3, v);       check("id_lit", v, 32'd16);
    wb_read("status0", 2'd1, v);  check("status0_lit", v, 32'd0);

    // 2: select project 5, measure sequence timing
    wb_write(BASE, 32'h105, t0);
    fall = -1; irqs = 0; prev = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cyc_n == t0 + G)     check("gap_last_off", 32'(active), 32'd0);
      if (cyc_n == t0 + G + 1) check("first_on", 32'(active), 32'h0020);
      if (prev && !prst && fall < 0) fall = cyc_n;
      prev = prst;
      irqs += int'(irq);
    end
    check("rst_fall_latency", 32'(fall - t0), 32'd13);
    check("irq_count", 32'(irqs), 32'd1);
    wb_read("status_run5", 2'd1, v); check("status_run5_lit", v, 32'h105);
    wb_read("swc1", 2'd2, v);        check("swc1_lit", v, 32'd1);
    wb_read("ctrl_rb", 2'd0, v);     check("ctrl_rb_lit", v, 32'h105);

    // 3: switch 5 -> 9
    wb_write(BASE, 32'h109, t0);
    idle(20); #1;
    check("run9_lit", 32'(active), 32'h0200);
    wb_read("swc2", 2'd2, v);  check("swc2_lit", v, 32'd2);

    // 4: write while busy is rejected and flags err; clear err
    wb_write(BASE, 32'h105, t0);
    wb_write(BASE, 32'h103, t);
    check("busy_write_gap", 32'(t - t0), 32'd2);
    idle(20); #1;
    check("busy_final_lit", 32'(active), 32'h0020);
    wb_read("status_err", 2'd1, v);  check("status_err_lit", v, 32'h505);
    wb_write(BASE | 32'h4, 32'h400, t);
    wb_read("status_clr", 2'd1, v);  check("status_clr_lit", v, 32'h105);

    // 5: out-of-range index, then all-off
    wb_write(BASE, 32'h114, t0);
    idle(12); #1;
    check("bad_idx_off", 32'(active), 32'd0);
    wb_read("status_bad", 2'd1, v);  check("status_bad_lit", v, 32'h405);
    wb_write(BASE, 32'h000, t0);
    wb_read("status_busy", 2'd1, v); check("status_busy_lit", v, 32'h605);
    idle(6);
    wb_read("status_off", 2'd1, v);  check("status_off_lit", v, 32'h405);
    wb_write(BASE | 32'h4, 32'h400, t);

    // Held strobe: one ack every other cycle
    idle(2);
    ack_chk = 1'b0;
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE | 32'hC;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("held_ack", 32'(ack), 32'(i % 2 == 0));
      if (ack) check("held_id", rdat, 32'd16);
    end
    stb = 1'b0; cyc = 1'b0;
    @(posedge clk); #1;
    ack_chk = 1'b1;

    // Random traffic against the model
    for (int it = 0; it < 40; it++) begin
      int unsigned op;
      logic [31:0] d;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3, 4: begin
          d = {23'b0, 1'($urandom_range(0, 5) != 0), 8'($urandom_range(0, 19))};
          wb_write(BASE, d, t);
        end
        5: wb_read("rnd_status", 2'd1, v);
        6: wb_read("rnd_swc", 2'd2, v);
        7: wb_write(BASE | 32'h4, 32'($urandom_range(0, 1)) << 10, t);
        8: wb_read("rnd_ctrl", 2'd0, v);
        default: wb_write(BASE | 32'h8, $urandom, t);
      endcase
      if ($urandom_range(0, 3) == 0) wb_acc(1'b0, BASE + 32'h100, 32'd0, v, t);
      idle($urandom_range(0, 18));
    end
    idle(20);

    // 6: async reset while the new slot is held in reset
    wb_write(BASE, 32'h107, t0);
    for (int i = 0; i < 20 && cyc_n < t0 + G + 3; i++) @(negedge clk);
    check("pre_reset_on", 32'(active), 32'h0080);
    #2;
    in_reset = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async_active", 32'(active), 32'd0);
    check("async_proj_rst", 32'(prst), 32'd1);
    check("async_irq", 32'(irq), 32'd0);
    idle(2);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; in_reset = 1'b0;
    idle(15);
    wb_acc(1'b0, BASE + 32'h100, 32'd0, v, t);
    wb_read("status_after_rst", 2'd1, v); check("status_after_rst_lit", v, 32'd0);
    wb_read("swc_after_rst", 2'd2, v);    check("swc_after_rst_lit", v, 32'd0);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
